dmem_arbiter: RTL and testbench

- Shares one synchronous single-port data memory between two requesters using a request/acknowledge handshake.
- Port 0 is the CPU-side bus adapter; port 1 is an auxiliary master such as a program loader, I/O DMA or debug monitor.
- A 4-state FSM sequences each transaction: latch, memory access, read-data wait, acknowledge.
- Round-robin priority breaks ties so neither requester starves. The block sits between the masters and the data memory/I/O decode.

---
 rtl/dmem_arb_pkg.sv | 15 +
 rtl/dmem_rr_pick.sv | 23 ++
 rtl/dmem_arbiter.sv | 120 ++++++++++++
 tb/tb_dmem_arbiter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// State encoding and port indices used by the arbiter and its selector.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic P_CPU = 1'b0;
    localparam logic P_AUX = 1'b1;

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-way round-robin selector.
// On a tie the port that did not win last time is chosen.
module dmem_rr_pick
    import dmem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic valid,
    output logic winner
);

    always_comb begin
        valid  = req0 | req1;
        winner = P_CPU;
        if (req0 && req1) begin
            winner = ~last;
        end else if (req1) begin
            winner = P_AUX;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for a synchronous single-port data memory.
// Each transaction walks IDLE -> ACCESS -> WAIT -> DONE.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          owner
);

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;

    logic pick_valid;
    logic pick_winner;

    dmem_rr_pick u_pick (
        .req0   (m0_req),
        .req1   (m1_req),
        .last   (last_q),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_winner;
                    last_d  = pick_winner;
                    we_d    = pick_winner ? m1_we    : m0_we;
                    addr_d  = pick_winner ? m1_addr  : m0_addr;
                    wdata_d = pick_winner ? m1_wdata : m0_wdata;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: state_d = ST_WAIT;
            ST_WAIT: begin
                // Memory returns read data one cycle after the strobe.
                if (!we_q) begin
                    if (owner_q == P_AUX) rdata1_d = mem_rdata;
                    else                  rdata0_d = mem_rdata;
                end
                state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            owner_q  <= P_CPU;
            last_q   <= P_AUX;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Strobes decode straight from state so a reset drops them at once.
    assign mem_en    = (state_q == ST_ACCESS);
    assign mem_we    = mem_en & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign m0_ack    = (state_q == ST_DONE) && (owner_q == P_CPU);
    assign m1_ack    = (state_q == ST_DONE) && (owner_q == P_AUX);
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;
    assign busy      = (state_q != ST_IDLE);
    assign owner     = owner_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: expectations queued at issue,
// a monitor thread pops and compares on mem_en and ack.
module tb_dmem_arbiter;

    logic        clock = 1'b0;
    logic        resetn = 1'b1;
    logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
    logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
    logic        m0_ack, m1_ack, mem_en, mem_we, busy, owner;
    logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mexp_t;

    mexp_t       mq0[$], mq1[$];
    logic [31:0] aq0[$], aq1[$];
    logic        grant_log[$];
    int          ack_log[$];
    logic [31:0] exp_rd [2];
    int          checks = 0, failures = 0, cyc = 0;

    dmem_arbiter #(.AW(32), .DW(32)) dut (
        .clock(clock), .resetn(resetn),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .owner(owner)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEADBEEF;
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    // Synchronous memory model: read data one cycle after mem_en.
    always @(posedge clock)
        if (mem_en && !mem_we) mem_rdata <= mem_fn(mem_addr);

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic monitor();
        mexp_t e;
        logic [31:0] r;
        forever begin
            @(negedge clock);
            cyc++;
            chk("we_without_en", {31'd0, mem_we & ~mem_en}, 0);
            chk("dual_ack", {31'd0, m0_ack & m1_ack}, 0);
            if (mem_en) begin
                grant_log.push_back(owner);
                if ((owner ? mq1.size() : mq0.size()) == 0) begin
                    chk("unexpected_mem_en_port", {31'd0, owner}, 32'hFFFFFFFF);
                end else begin
                    e = owner ? mq1.pop_front() : mq0.pop_front();
                    chk("mem_we", {31'd0, mem_we}, {31'd0, e.we});
                    chk("mem_addr", mem_addr, e.addr);
                    if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
                end
            end
            if (m0_ack) begin
                ack_log.push_back(cyc);
                if (aq0.size() == 0) chk("unexpected_m0_ack", 1, 0);
                else begin
                    r = aq0.pop_front();
                    chk("m0_rdata", m0_rdata, r);
                end
            end
            if (m1_ack) begin
                ack_log.push_back(cyc);
                if (aq1.size() == 0) chk("unexpected_m1_ack", 1, 0);
                else begin
                    r = aq1.pop_front();
                    chk("m1_rdata", m1_rdata, r);
                end
            end
        end
    endtask

    task automatic xfer(input bit p, input bit we, input logic [31:0] a,
                        input logic [31:0] d, input int lat);
        mexp_t e;
        int    n = 0;
        bit    got = 0;
        e.we = we; e.addr = a; e.wdata = d;
        if (!we) exp_rd[p] = mem_fn(a);
        if (p) begin
            mq1.push_back(e); aq1.push_back(exp_rd[1]);
            m1_we = we; m1_addr = a; m1_wdata = d; m1_req = 1;
        end else begin
            mq0.push_back(e); aq0.push_back(exp_rd[0]);
            m0_we = we; m0_addr = a; m0_wdata = d; m0_req = 1;
        end
        while (!got && n < 30) begin
            @(negedge clock);
            n++;
            got = p ? m1_ack : m0_ack;
        end
        if (!got) chk("ack_timeout", 0, 1);
        else if (lat > 0) chk("ack_latency", n, lat);
        @(posedge clock); #1;
        if (p) m1_req = 0; else m0_req = 0;
    endtask

    initial begin
        exp_rd[0] = 0; exp_rd[1] = 0;
        fork monitor(); join_none
        #1 resetn = 0;
        @(posedge clock); #1;

        // Reset held with both requesting, then release: port 0 first.
        fork
            xfer(0, 0, 32'h10, 32'h0, 0);
            xfer(1, 1, 32'h44, 32'hA5A5A5A5, 0);
            begin
                @(negedge clock);
                chk("rst_outputs", {m0_ack, m1_ack, mem_en, mem_we, busy, owner}, 0);
                chk("rst_data", m0_rdata | m1_rdata | mem_addr | mem_wdata, 0);
                @(posedge clock); #1 resetn = 1;
                @(negedge clock);
                chk("rel_cycle1_en", {31'd0, mem_en}, 0);
                @(negedge clock);
                chk("rel_cycle2_en", {31'd0, mem_en}, 1);
                chk("rel_owner", {31'd0, owner}, 0);
            end
        join

        xfer(0, 0, 32'h10, 32'h0, 4);
        xfer(1, 1, 32'h20, 32'h12345678, 4);

        // Contention: both hold requests for four transactions each.
        grant_log.delete();
        ack_log.delete();
        fork
            for (int i = 0; i < 4; i++)
                xfer(0, 0, 32'h100 + i * 4, 32'h0, i == 0 ? 4 : 8);
            for (int j = 0; j < 4; j++)
                xfer(1, j[0], 32'h200 + j * 4, 32'hC0DE0000 + j, 8);
        join
        chk("grant_count", grant_log.size(), 8);
        chk("ack_count", ack_log.size(), 8);
        for (int i = 0; i < 8 && i < grant_log.size(); i++)
            chk($sformatf("grant_order_%0d", i), {31'd0, grant_log[i]}, i % 2);
        for (int i = 1; i < 8 && i < ack_log.size(); i++)
            chk($sformatf("ack_spacing_%0d", i), ack_log[i] - ack_log[i-1], 4);

        // Abort a write in ACCESS.
        m1_we = 1; m1_addr = 32'h30; m1_wdata = 32'hBAD0BAD0; m1_req = 1;
        @(posedge clock); #2;
        chk("abort_pre_en", {30'd0, mem_en, mem_we}, 3);
        resetn = 0;
        #1;
        chk("abort_strobes", {30'd0, mem_en, mem_we}, 0);
        chk("abort_busy_owner", {30'd0, busy, owner}, 0);
        m1_req = 0;
        exp_rd[0] = 0; exp_rd[1] = 0;
        @(negedge clock);
        @(posedge clock); #1 resetn = 1;
        xfer(1, 1, 32'h30, 32'hBAD0BAD0, 4);

        // Withdrawn m1 request during m0 WAIT.
        fork
            xfer(0, 0, 32'h40, 32'h0, 4);
            begin
                @(posedge clock); @(posedge clock); #1;
                m1_we = 0; m1_addr = 32'h50; m1_req = 1;
                @(posedge clock); #1 m1_req = 0;
                repeat (4) begin
                    @(negedge clock);
                    chk("withdrawn_no_en", {31'd0, mem_en}, 0);
                end
            end
        join

        repeat (2) @(negedge clock);
        chk("sb_empty", mq0.size() + mq1.size() + aq0.size() + aq1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
